// File: rtl/apb_master_bridge.sv
// APB master bridge: valid/ready command stream to APB SETUP/ACCESS transfers.
// One transfer in flight; a wait-state timeout aborts with an error response.
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              pwrite_q;
    logic              psel_q;
    logic              penable_q;
    logic              rvalid_q;
    logic              rerr_q;
    logic              timed_out;

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_V);

    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign rsp_valid = rvalid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr_q  <= cmd_addr;
                        pwrite_q <= cmd_write;
                        pwdata_q <= cmd_write ? cmd_wdata : '0;
                        psel_q   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // completion takes priority over a timeout in the same cycle
                    if (pready) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= pwrite_q ? '0 : prdata;
                        rerr_q    <= 1'b0;
                        state_q   <= RESP;
                    end else if (timed_out) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= '0;
                        rerr_q    <= 1'b1;
                        state_q   <= RESP;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rvalid_q <= 1'b0;
                        rdata_q  <= '0;
                        rerr_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge (TIMEOUT=16).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input int waits, input logic [31:0] prd,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = wd;
        pready    = 1'b0;
        prdata    = 32'hBAD0BAD0;
        chk({tag, "_ready"}, cmd_ready, 1);
        step();
        cyc = 1;
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'h5555_5555;
        chk({tag, "_setup"}, {psel, penable}, 2'b10);
        step();
        cyc = 2;
        for (int c = 0; c < 40; c++) begin
            chk({tag, "_access"}, {psel, penable, rsp_valid}, 3'b110);
            if (c == 0) begin
                chk({tag, "_paddr"}, paddr, a);
                chk({tag, "_pwrite"}, pwrite, w);
                chk({tag, "_pwdata"}, pwdata, w ? wd : 32'h0);
            end
            if (c == waits) begin
                pready = 1'b1;
                prdata = prd;
            end
            step();
            cyc++;
            if (rsp_valid) break;
        end
        pready = 1'b0;
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_rsp"}, {rsp_valid, rsp_err, psel, penable}, {1'b1, exp_err, 2'b00});
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_hold_addr"}, paddr, a);
        step();
        chk({tag, "_idle"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        prdata    = 32'h0;
        pready    = 1'b0;

        step();
        step();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_outs", {rsp_valid, rsp_err, psel, penable, pwrite}, 5'b0);
        chk("rst_data", {paddr, pwdata}, 64'h0);
        chk("rst_rdata", rsp_rdata, 0);
        rst = 1'b0;
        #1;
        chk("idle_ready", cmd_ready, 1);

        xfer("wr0", 32'h1000, 1'b1, 32'hDEADBEEF, 0, 32'h0, 3, 32'h0, 1'b0);
        xfer("rd3", 32'h20, 1'b0, 32'h0, 3, 32'hA5A50001, 6, 32'hA5A50001, 1'b0);
        xfer("tmo", 32'h30, 1'b0, 32'h0, 99, 32'h0, 19, 32'h0, 1'b1);
        xfer("rdok", 32'h34, 1'b0, 32'h0, 0, 32'h0BADF00D, 3, 32'h0BADF00D, 1'b0);
        xfer("tie", 32'h38, 1'b0, 32'h0, 16, 32'h600DCAFE, 19, 32'h600DCAFE, 1'b0);

        // backpressure with a second command waiting
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h40;
        cmd_write = 1'b0;
        cmd_wdata = 32'h0;
        step();
        cmd_addr  = 32'h50;
        cmd_write = 1'b1;
        cmd_wdata = 32'hCAFEF00D;
        pready    = 1'b1;
        prdata    = 32'h11112222;
        chk("bp_setup_ready", cmd_ready, 0);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", cmd_ready, 0);
            chk("bp_rsp", {rsp_valid, rsp_err}, 2'b10);
            chk("bp_rdata", rsp_rdata, 32'h11112222);
            chk("bp_paddr", paddr, 32'h40);
            prdata = 32'h99999999;
            step();
        end
        chk("bp_still", rsp_valid, 1);
        rsp_ready = 1'b1;
        step();
        chk("bp_hs_idle", {rsp_valid, psel, cmd_ready}, 3'b001);
        step();
        cmd_valid = 1'b0;
        chk("bp_second", {psel, penable}, 2'b10);
        chk("bp_second_addr", paddr, 32'h50);
        chk("bp_second_wdata", pwdata, 32'hCAFEF00D);
        step();
        step();
        chk("bp_second_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("bp_second_rdata", rsp_rdata, 0);
        step();
        pready = 1'b0;

        // reset during a wait state
        cmd_valid = 1'b1;
        cmd_addr  = 32'h60;
        cmd_write = 1'b1;
        cmd_wdata = 32'h77778888;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("mr_wait", {psel, penable}, 2'b11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_outs", {rsp_valid, rsp_err, psel, penable, pwrite}, 5'b0);
        chk("mr_data", {paddr, pwdata}, 64'h0);
        chk("mr_rdata", rsp_rdata, 0);
        #1;
        chk("mr_ready", cmd_ready, 1);
        step();
        step();
        chk("mr_norsp", {rsp_valid, psel}, 2'b00);

        xfer("post", 32'h70, 1'b0, 32'h0, 1, 32'h13572468, 4, 32'h13572468, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
